// File: rtl/hough_pkg.sv
// Shared types for the Hough front end: column geometry, pixel and column
// containers, and the state encoding of the greyscale column sink.
package hough_pkg;

  localparam int COL_H = 256;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Packed so that element i (row i) is directly indexable on a port.
  typedef pixel_t [COL_H-1:0] grey_col_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } sink_state_t;

endpackage

// File: rtl/col_serializer.sv
// Column buffer plus beat multiplexer: captures one full greyscale column on
// load and presents LANES consecutive rows per beat, lowest row in the low byte.
module col_serializer
  import hough_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                   clock,
  input  logic                   load,
  input  logic [7:0]             beat,
  input  grey_col_t              data_in,
  output logic [LANES*PIX_W-1:0] lane_data
);

  grey_col_t col_buf_p0;

  // Capture stage: buffer only changes on an accepted transfer, so it is
  // stable for the whole serialisation even if the upstream bus moves.
  always_ff @(posedge clock) begin
    if (load) begin
      col_buf_p0 <= data_in;
    end
  end

  // Serialise stage: select rows beat*LANES .. beat*LANES+LANES-1.
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_data[k*PIX_W +: PIX_W] = col_buf_p0[8'(int'(beat) * LANES + k)];
    end
  end

endmodule

// File: rtl/grey_col_sink.sv
// Greyscale column sink: accepts 256-row columns and writes them into an
// output RAM LANES pixels per beat, column-major, counting columns per frame.
// Optional build macro GREY_SINK_CHECKSUM_EN adds a per-frame pixel checksum.
module grey_col_sink
  import hough_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int ADDR_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   data_rdy_in,
  input  grey_col_t              data_in,
  output logic                   data_req_out,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [LANES*PIX_W-1:0] wr_data,
  output logic [7:0]             col_count,
  output logic                   frame_done
`ifdef GREY_SINK_CHECKSUM_EN
  ,
  output logic [31:0]            checksum
`endif
);

  localparam int         BEATS     = COL_H / LANES;
  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);
  localparam logic [7:0] LAST_COL  = 8'd255;

  sink_state_t state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  col_q, col_d;
  logic        load;

  // Strobes are decoded from state and held low while reset is asserted so
  // nothing is requested or written during the reset cycle itself.
  assign data_req_out = (state_q == IDLE)  && !reset;
  assign wr_en        = (state_q == WRITE) && !reset;
  assign frame_done   = (state_q == DONE)  && !reset;
  assign load         = data_req_out && data_rdy_in;
  assign col_count    = col_q;

  // Column-major address: each column occupies BEATS consecutive words.
  assign wr_addr = ADDR_W'(col_q) * ADDR_W'(BEATS) + ADDR_W'(beat_q);

  col_serializer #(
    .LANES     (LANES)
  ) u_ser (
    .clock     (clock),
    .load      (load),
    .beat      (beat_q),
    .data_in   (data_in),
    .lane_data (wr_data)
  );

  // Next-state logic: accept a column in IDLE, stream it in WRITE, pulse DONE
  // once after the last column of the frame.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (data_rdy_in) begin
          state_d = WRITE;
          beat_d  = '0;
        end
      end
      WRITE: begin
        beat_d = beat_q + 8'd1;
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (col_q != LAST_COL) begin
            col_d   = col_q + 8'd1;
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        col_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        col_d   = '0;
      end
    endcase
  end

  // Control registers; a reset mid-column abandons it and restarts the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      col_q   <= col_d;
    end
  end

`ifdef GREY_SINK_CHECKSUM_EN
  logic [31:0] csum_q;

  function automatic logic [31:0] lane_sum(input logic [LANES*PIX_W-1:0] d);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      s = s + 32'(d[k*PIX_W +: PIX_W]);
    end
    return s;
  endfunction

  // Frame checksum: wrapping sum of every written pixel, visible during DONE
  // and cleared on the following cycle.
  always_ff @(posedge clock) begin
    if (reset || (state_q == DONE)) begin
      csum_q <= '0;
    end else if (wr_en) begin
      csum_q <= csum_q + lane_sum(wr_data);
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_grey_col_sink.sv
// Self-checking bench for grey_col_sink (LANES=4). A queue of expected RAM
// writes is built from each accepted column and compared against the DUT.
module tb_grey_col_sink;
  import hough_pkg::*;

  localparam int LANES  = 4;
  localparam int ADDR_W = 16;
  localparam int BEATS  = COL_H / LANES;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   data_rdy_in = 1'b0;
  grey_col_t              data_in = '0;
  logic                   data_req_out;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [LANES*8-1:0]     wr_data;
  logic [7:0]             col_count;
  logic                   frame_done;
`ifdef GREY_SINK_CHECKSUM_EN
  logic [31:0]            checksum;
  logic [31:0]            sb_sum = '0;
  logic [31:0]            done_csum = '0;
`endif

  int checks = 0;
  int errors = 0;
  int model_col = 0;
  int done_pulses = 0;
  bit done_exp = 1'b0;

  typedef struct {
    int                 addr;
    logic [LANES*8-1:0] data;
    logic [31:0]        sum;
    bit                 last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  grey_col_sink #(
    .LANES        (LANES),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .data_rdy_in  (data_rdy_in),
    .data_in      (data_in),
    .data_req_out (data_req_out),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .col_count    (col_count),
    .frame_done   (frame_done)
`ifdef GREY_SINK_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 3000000", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference: an accepted column yields BEATS writes at consecutive words
  // starting at column*BEATS, packing rows low byte first.
  task automatic model_push(input grey_col_t c);
    exp_t x;
    for (int b = 0; b < BEATS; b++) begin
      x.addr = model_col * BEATS + b;
      x.sum  = '0;
      x.data = '0;
      for (int k = 0; k < LANES; k++) begin
        x.data[k*8 +: 8] = c[b*LANES + k];
        x.sum = x.sum + 32'(c[b*LANES + k]);
      end
      x.last = (model_col == 255) && (b == BEATS - 1);
      exp_q.push_back(x);
    end
    model_col = (model_col + 1) % 256;
  endtask

  // Scoreboard on the falling edge: writes, frame pulse and running checksum.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      done_exp = 1'b0;
      model_col = 0;
`ifdef GREY_SINK_CHECKSUM_EN
      sb_sum = '0;
`endif
    end else begin
      checks++;
      if (frame_done !== done_exp) begin
        errors++;
        $display("FAIL frame_done at %0t: got %b, required %b", $time, frame_done, done_exp);
      end
`ifdef GREY_SINK_CHECKSUM_EN
      checks++;
      if (checksum !== sb_sum) begin
        errors++;
        $display("FAIL checksum_run at %0t: got %0d, required %0d", $time, checksum, sb_sum);
      end
      if (frame_done === 1'b1) begin
        done_csum = checksum;
        sb_sum = '0;
      end
`endif
      if (frame_done === 1'b1) done_pulses++;
      done_exp = 1'b0;
      if (wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write at %0t: addr %0d data %h, required no write", $time, wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== ADDR_W'(e.addr) || wr_data !== e.data) begin
            errors++;
            $display("FAIL write at %0t: addr %0d data %h, required addr %0d data %h",
                     $time, wr_addr, wr_data, e.addr, e.data);
          end
`ifdef GREY_SINK_CHECKSUM_EN
          sb_sum = sb_sum + e.sum;
`endif
          if (e.last) done_exp = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    data_rdy_in = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_col = 0;
  endtask

  task automatic wait_req(input int max_cyc);
    int n;
    n = 0;
    while (data_req_out !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    if (data_req_out !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_req: data_req_out=%b, required 1 within %0d cycles", data_req_out, max_cyc);
    end
  endtask

  // Offer one column, leave ready low afterwards; returns just after the transfer edge.
  task automatic send_column(input grey_col_t c);
    wait_req(600);
    data_in = c;
    data_rdy_in = 1'b1;
    model_push(c);
    step();
    data_rdy_in = 1'b0;
  endtask

  task automatic drain(input string name);
    wait_req(600);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  function automatic grey_col_t ramp_col();
    grey_col_t c;
    for (int i = 0; i < COL_H; i++) c[i] = 8'(i);
    return c;
  endfunction

  function automatic grey_col_t rand_col();
    grey_col_t c;
    for (int i = 0; i < COL_H; i++) c[i] = 8'($urandom);
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    data_rdy_in = 1'b1;
    data_in = rand_col();
    step();
    checks++;
    if (data_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", data_req_out); end
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
    step();
    reset = 1'b0;
    data_rdy_in = 1'b0;
    model_col = 0;
    #1;
    checks++;
    if (data_req_out !== 1'b1) begin errors++; $display("FAIL reset_req_after: got %b, required 1", data_req_out); end
    checks++;
    if (col_count !== 8'd0) begin errors++; $display("FAIL reset_col_count: got %0d, required 0", col_count); end
    step();
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_no_write: got %b, required 0", wr_en); end
  endtask

  task automatic test_single();
    logic [LANES*8-1:0] first;
    int n_we, n_req;
    apply_reset();
    for (int k = 0; k < LANES; k++) first[k*8 +: 8] = 8'(k);
    send_column(ramp_col());
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== first) begin
      errors++;
      $display("FAIL single_first_beat: wr_en %b addr %0d data %h, required 1 0 %h", wr_en, wr_addr, wr_data, first);
    end
    n_we = 0;
    n_req = 0;
    for (int i = 0; i < BEATS; i++) begin
      if (wr_en === 1'b1) n_we++;
      if (data_req_out !== 1'b0) n_req++;
      step();
    end
    checks++;
    if (n_we != BEATS) begin errors++; $display("FAIL single_beats: got %0d, required %0d", n_we, BEATS); end
    checks++;
    if (n_req != 0) begin errors++; $display("FAIL single_req_during_write: got %0d cycles, required 0", n_req); end
    checks++;
    if (data_req_out !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_return_idle: req %b wr_en %b, required 1 0", data_req_out, wr_en);
    end
    checks++;
    if (col_count !== 8'd1) begin errors++; $display("FAIL single_col_count: got %0d, required 1", col_count); end
    drain("single");
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    data_rdy_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      data_in = rand_col();
      if (data_req_out !== 1'b1 || wr_en !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_hold: %0d bad cycles, required 0", bad); end
    checks++;
    if (col_count !== 8'd1) begin errors++; $display("FAIL idle_col_count: got %0d, required 1", col_count); end
    send_column(rand_col());
    drain("idle");
  endtask

  task automatic test_back_to_back();
    logic [LANES*8-1:0] first;
    int guard;
    apply_reset();
    for (int k = 0; k < LANES; k++) first[k*8 +: 8] = 8'(k);
    data_rdy_in = 1'b1;
    data_in = ramp_col();
    model_push(data_in);
    step();
    guard = 0;
    while (data_req_out !== 1'b1 && guard < 400) begin step(); guard++; end
    checks++;
    if (guard != BEATS) begin errors++; $display("FAIL b2b_period: gap %0d, required %0d", guard, BEATS); end
    model_push(data_in);
    step();
    data_rdy_in = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(BEATS) || wr_data !== first) begin
      errors++;
      $display("FAIL b2b_second_first: wr_en %b addr %0d data %h, required 1 %0d %h", wr_en, wr_addr, wr_data, BEATS, first);
    end
    drain("b2b");
    checks++;
    if (col_count !== 8'd2) begin errors++; $display("FAIL b2b_col_count: got %0d, required 2", col_count); end
  endtask

  task automatic test_data_change();
    int guard;
    apply_reset();
    data_rdy_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      data_in = rand_col();
      model_push(data_in);
      step();
      guard = 0;
      while (data_req_out !== 1'b1 && guard < 400) begin
        data_in = rand_col();
        step();
        guard++;
      end
      checks++;
      if (guard != BEATS) begin errors++; $display("FAIL change_period: gap %0d, required %0d", guard, BEATS); end
    end
    data_rdy_in = 1'b0;
    step();
    drain("change");
    checks++;
    if (col_count !== 8'd3) begin errors++; $display("FAIL change_col_count: got %0d, required 3", col_count); end
  endtask

  task automatic test_random();
    int gap;
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      send_column(rand_col());
      wait_req(600);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        data_in = rand_col();
        step();
      end
    end
    drain("random");
    checks++;
    if (col_count !== 8'd6) begin errors++; $display("FAIL random_col_count: got %0d, required 6", col_count); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int n = 0; n < 6; n++) send_column(rand_col());
    for (int i = 0; i < 25; i++) step();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(5 * BEATS + 25)) begin
      errors++;
      $display("FAIL midrst_pre: wr_en %b addr %0d, required 1 %0d", wr_en, wr_addr, 5 * BEATS + 25);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_col = 0;
    #1;
    checks++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en: got %b, required 0", wr_en); end
    checks++;
    if (col_count !== 8'd0) begin errors++; $display("FAIL midrst_col_count: got %0d, required 0", col_count); end
    checks++;
    if (data_req_out !== 1'b1) begin errors++; $display("FAIL midrst_req: got %b, required 1", data_req_out); end
    send_column(rand_col());
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== '0) begin
      errors++;
      $display("FAIL midrst_restart: wr_en %b addr %0d, required 1 0", wr_en, wr_addr);
    end
    drain("midrst");
  endtask

  task automatic test_frame();
    grey_col_t ones;
    for (int i = 0; i < COL_H; i++) ones[i] = 8'h01;
    apply_reset();
    done_pulses = 0;
    for (int n = 0; n < 256; n++) send_column(ones);
    wait_req(600);
    checks++;
    if (done_pulses != 1) begin errors++; $display("FAIL frame_pulses: got %0d, required 1", done_pulses); end
    checks++;
    if (col_count !== 8'd0) begin errors++; $display("FAIL frame_wrap: got %0d, required 0", col_count); end
`ifdef GREY_SINK_CHECKSUM_EN
    checks++;
    if (done_csum !== 32'd65536) begin errors++; $display("FAIL frame_checksum: got %0d, required 65536", done_csum); end
    checks++;
    if (checksum !== 32'd0) begin errors++; $display("FAIL frame_checksum_clear: got %0d, required 0", checksum); end
`endif
    send_column(ones);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== '0) begin
      errors++;
      $display("FAIL frame_next_col: wr_en %b addr %0d, required 1 0", wr_en, wr_addr);
    end
    drain("frame");
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle();
    test_back_to_back();
    test_data_change();
    test_random();
    test_mid_reset();
    test_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grey_col_sink.md
GREY_COL_SINK -- requirements
Module: grey_col_sink

Interface
REQ-001 The block SHALL provide parameter LANES, default 1, giving pixels written per beat; legal values are 1, 2, 4, 8 and 16.
REQ-002 The block SHALL provide parameter ADDR_W, default 16, giving the output RAM address width; minimum 16.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_rdy_in  input  1  upstream greyscale column valid.
REQ-006 data_in  input  256x8  greyscale column; element i is row i.
REQ-007 data_req_out  output  1  sink ready to accept a column.
REQ-008 wr_en  output  1  output RAM write strobe.
REQ-009 wr_addr  output  ADDR_W  output RAM word address.
REQ-010 wr_data  output  LANES*8  pixels in this beat; lane k is row base+k, in the low byte first.
REQ-011 col_count  output  8  number of columns fully written in the current frame.
REQ-012 frame_done  output  1  one-cycle pulse when column 255 completes.

Function
REQ-013 A column SHALL transfer on any cycle where data_req_out and data_rdy_in are both 1; data_in SHALL be captured into an internal 256x8 buffer on that edge.
REQ-014 The FSM SHALL have three states: IDLE, WRITE and DONE.
REQ-015 IDLE: data_req_out=1 and wr_en=0; a transfer SHALL move the FSM to WRITE with beat counter 0.
REQ-016 WRITE: data_req_out=0; every cycle SHALL assert wr_en with wr_data = buffer rows beat*LANES..beat*LANES+LANES-1, and increment beat.
REQ-017 WRITE SHALL emit exactly 256/LANES beats; the first beat SHALL occur the cycle after the transfer.
REQ-018 wr_addr SHALL equal col_count*(256/LANES)+beat, zero-extended to ADDR_W.
REQ-019 After the last beat, if col_count<255 the FSM SHALL go to IDLE and col_count SHALL increment; otherwise it SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with frame_done=1, data_req_out=0 and wr_en=0; col_count SHALL then wrap to 0 and the FSM SHALL return to IDLE.
REQ-021 data_rdy_in asserted outside IDLE SHALL be ignored, and data_in SHALL not be sampled.
REQ-022 Back-to-back columns: the next transfer SHALL occur no earlier than the IDLE cycle following the last beat, giving a minimum period of 256/LANES+1 cycles per column.
REQ-023 The buffer SHALL NOT change during WRITE, even if data_in changes.

Reset
REQ-024 Reset SHALL force state IDLE, beat=0, col_count=0, wr_en=0, frame_done=0, and data_req_out=0 during the reset cycle, then 1 on the first cycle after reset.
REQ-025 Reset asserted mid-WRITE SHALL abort the column with no further wr_en; the partially written column SHALL be rewritten from row 0 after the next transfer.
REQ-026 Buffer contents SHALL be don't-care after reset.

Configuration
REQ-027 When macro GREY_SINK_CHECKSUM_EN is defined, the block SHALL add output checksum (32 bits), the wrapping sum of all pixels written in the frame.
REQ-028 With GREY_SINK_CHECKSUM_EN, checksum SHALL be valid in the frame_done cycle; it SHALL clear on reset and on the cycle after frame_done.
REQ-029 Without GREY_SINK_CHECKSUM_EN, the checksum port and its adder SHALL NOT exist.

Structure
REQ-030 The shared package hough_pkg SHALL hold COL_H=256, pixel_t (8-bit), grey_col_t (COL_H x pixel_t) and the sink state enum.
REQ-031 A sub-module col_serializer SHALL hold the buffer and the beat mux; it takes load, beat and data_in, and outputs the lane data.
REQ-032 The FSM, address generation, col_count and checksum logic SHALL reside in grey_col_sink.

Verification
REQ-033 LANES=1, single column with row i=i: transfer at cycle T -> wr_en cycles T+1..T+256; wr_addr 0..255; wr_data 0x00..0xFF; data_req_out high again at T+257.
REQ-034 LANES=4, two back-to-back columns -> column 1 wr_addr 64..127; first word wr_data=0x03020100; col_count=2.
REQ-035 256 columns of all-0x01 with GREY_SINK_CHECKSUM_EN -> exactly one frame_done pulse; checksum=65536; col_count wraps to 0; the 257th column writes wr_addr 0.
REQ-036 data_rdy_in held high throughout, with data_in changed every cycle during WRITE -> written data matches the captured column only.
REQ-037 Reset at beat 100 of column 5 -> wr_en low the next cycle; col_count=0; the next column writes from wr_addr 0.
REQ-038 data_rdy_in=0 for 50 cycles in IDLE -> data_req_out stays 1; no wr_en; no state change.
